// File: rtl/instr_decode_queue.sv
// Multi-lane RV32 decode stage feeding an in-order circular buffer that drains one entry per cycle.
// Define DECODE_QUEUE_BYPASS_EN to let lane 0 go straight to out_* when the buffer is empty.
module instr_decode_queue #(
  parameter int LANES = 2,
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES-1:0]         in_mask,
  input  logic [32*LANES-1:0]      in_data,
  input  logic [XLEN-1:0]          in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN+21:0]         out_data,
  output logic [XLEN-1:0]          out_pc,
  output logic [$clog2(DEPTH):0]   out_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [3:0] {
    INSTR_INVAL, INSTR_LOAD, INSTR_MISC_MEM, INSTR_OP_IMM, INSTR_AUIPC, INSTR_STORE,
    INSTR_OP, INSTR_LUI, INSTR_BRANCH, INSTR_JALR, INSTR_JAL, INSTR_SYSTEM
  } op_e;

  typedef enum logic [2:0] {F_I, F_U, F_S, F_R, F_B, F_J} fmt_e;

  typedef struct packed {
    op_e             op;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic [2:0]      funct3;
  } decoded_instr;

  function automatic decoded_instr decode(input logic [31:0] i);
    decoded_instr d;
    fmt_e         fmt;
    logic [31:0]  raw;
    d        = '0;
    d.op     = INSTR_INVAL;
    d.funct3 = i[14:12];
    fmt      = F_I;
    raw      = '0;
    if (i[1:0] == 2'b11) begin
      case (i[6:2])
        5'b00000: begin d.op = INSTR_LOAD;     fmt = F_I; end
        5'b00011: begin d.op = INSTR_MISC_MEM; fmt = F_I; end
        5'b00100: begin d.op = INSTR_OP_IMM;   fmt = F_I; end
        5'b00101: begin d.op = INSTR_AUIPC;    fmt = F_U; end
        5'b01000: begin d.op = INSTR_STORE;    fmt = F_S; end
        5'b01100: begin d.op = INSTR_OP;       fmt = F_R; end
        5'b01101: begin d.op = INSTR_LUI;      fmt = F_U; end
        5'b11000: begin d.op = INSTR_BRANCH;   fmt = F_B; end
        5'b11001: begin d.op = INSTR_JALR;     fmt = F_I; end
        5'b11011: begin d.op = INSTR_JAL;      fmt = F_J; end
        5'b11100: begin d.op = INSTR_SYSTEM;   fmt = F_I; end
        default:  d.op = INSTR_INVAL;
      endcase
    end
    if (d.op != INSTR_INVAL) begin
      case (fmt)
        F_S:     raw = {{20{i[31]}}, i[31:25], i[11:7]};
        F_B:     raw = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
        F_U:     raw = {i[31:12], 12'b0};
        F_J:     raw = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
        default: raw = {{20{i[31]}}, i[31:20]};  // I and R share the I layout
      endcase
      d.imm = XLEN'($signed(raw));
      d.rs1 = (fmt inside {F_U, F_J})      ? 5'd0 : i[19:15];
      d.rs2 = (fmt inside {F_U, F_J, F_I}) ? 5'd0 : i[24:20];
      d.rd  = (fmt inside {F_S, F_B})      ? 5'd0 : i[11:7];
    end
    return d;
  endfunction

  decoded_instr    mem    [DEPTH];
  logic [XLEN-1:0] pc_mem [DEPTH];
  decoded_instr    lane_dec [LANES];
  logic [AW-1:0]   head, tail;
  logic [CW-1:0]   cnt, n_in, n_wr;
  logic            enq, deq, bypass;

  always_comb begin
    for (int i = 0; i < LANES; i++) lane_dec[i] = decode(in_data[32*i +: 32]);
  end

  always_comb begin
    n_in = '0;
    for (int i = 0; i < LANES; i++) n_in = n_in + CW'(in_mask[i]);
    in_ready = !flush && (cnt <= CW'(DEPTH - LANES));
    enq      = in_valid && in_ready;
`ifdef DECODE_QUEUE_BYPASS_EN
    bypass    = enq && in_mask[0] && (cnt == '0) && out_ready;
    out_valid = ((cnt != '0) || (in_valid && in_mask[0] && in_ready)) && !flush;
    out_data  = (cnt == '0) ? lane_dec[0] : mem[head];
    out_pc    = (cnt == '0) ? in_pc : pc_mem[head];
`else
    bypass    = 1'b0;
    out_valid = (cnt != '0) && !flush;
    out_data  = mem[head];
    out_pc    = pc_mem[head];
`endif
    deq  = out_valid && out_ready && !bypass;
    n_wr = bypass ? n_in - CW'(1) : n_in;
  end

  // Lanes are contiguous from lane 0, so lane i lands at tail+i (tail+i-1 when lane 0 bypassed).
  always_ff @(posedge clk) begin
    if (!rst && enq) begin
      for (int i = 0; i < LANES; i++) begin
        if (in_mask[i] && !(bypass && i == 0)) begin
          mem[tail + AW'(bypass ? i - 1 : i)]    <= lane_dec[i];
          pc_mem[tail + AW'(bypass ? i - 1 : i)] <= in_pc + XLEN'(4 * i);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (enq) tail <= tail + AW'(n_wr);
      if (deq) head <= head + AW'(1);
      cnt <= cnt + (enq ? n_wr : CW'(0)) - (deq ? CW'(1) : CW'(0));
    end
  end

  assign out_count = cnt;

endmodule

// File: tb/tb_instr_decode_queue.sv
// Directed bench for instr_decode_queue: decode table plus fill, wrap, flush, reset and latency sequences.
module tb_instr_decode_queue;
  localparam int LANES = 2, DEPTH = 4, XLEN = 32;

  localparam logic [3:0] OP_INVAL = 4'd0, OP_OP_IMM = 4'd3, OP_STORE = 4'd5, OP_OP = 4'd6,
                         OP_LUI = 4'd7, OP_BRANCH = 4'd8, OP_JAL = 4'd10;

  localparam logic [31:0] I_A = 32'h00500093;  // addi x1,x0,5
  localparam logic [31:0] I_B = 32'h000000B7;  // lui x1,0
  localparam logic [31:0] I_Z = 32'h00000000;  // invalid
  localparam logic [31:0] I_Q = 32'hFE000EE3;  // beq x0,x0,-4
  localparam logic [31:0] I_S = 32'h0020A423;  // sw x2,8(x1)
  localparam logic [31:0] I_J = 32'h010000EF;  // jal x1,16
  localparam logic [31:0] I_R = 32'h002081B3;  // add x3,x1,x2
  localparam logic [31:0] I_X = 32'h0000707F;  // unlisted opcode, funct3=7

  logic clk = 1'b0;
  logic rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [LANES-1:0]       in_mask;
  logic [32*LANES-1:0]    in_data;
  logic [XLEN-1:0]        in_pc, out_pc;
  logic [XLEN+21:0]       out_data;
  logic [$clog2(DEPTH):0] out_count;

  instr_decode_queue #(.LANES(LANES), .DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_mask(in_mask), .in_data(in_data), .in_pc(in_pc), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_pc(out_pc), .out_count(out_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (!rst && in_valid)
      assert ((in_mask & (in_mask + 2'd1)) == 2'b00) else $error("non-contiguous in_mask %b", in_mask);

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] m, input logic [31:0] d0, input logic [31:0] d1,
                       input logic [31:0] pc, input logic ordy, input logic fl);
    @(negedge clk);
    in_valid  = v;
    in_mask   = m;
    in_data   = {d1, d0};
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    #1;
  endtask

  task automatic idle(input logic ordy);
    drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, ordy, 1'b0);
  endtask

  task automatic chk_flow(input string p, input logic v, input logic r, input logic [2:0] c);
    chk({p, ".out_valid"}, out_valid, v);
    chk({p, ".in_ready"}, in_ready, r);
    chk({p, ".out_count"}, out_count, c);
  endtask

  task automatic chk_dec(input string p, input logic [3:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [31:0] imm, input logic [2:0] f3, input logic [31:0] pc);
    chk({p, ".op"}, out_data[53:50], op);
    chk({p, ".rs1"}, out_data[49:45], rs1);
    chk({p, ".rs2"}, out_data[44:40], rs2);
    chk({p, ".rd"}, out_data[39:35], rd);
    chk({p, ".imm"}, out_data[34:3], imm);
    chk({p, ".funct3"}, out_data[2:0], f3);
    chk({p, ".pc"}, out_pc, pc);
  endtask

  typedef struct {
    logic v; logic [1:0] m; logic [31:0] d0, d1, pc; logic ordy;
    logic e_v, e_r; logic [2:0] e_cnt;
    logic [3:0] e_op; logic [4:0] e_rs1, e_rs2, e_rd; logic [31:0] e_imm; logic [2:0] e_f3; logic [31:0] e_pc;
  } vec_t;

  function automatic vec_t mk(logic v, logic [1:0] m, logic [31:0] d0, logic [31:0] d1, logic [31:0] pc,
                              logic ordy, logic e_v, logic e_r, logic [2:0] e_cnt, logic [3:0] e_op,
                              logic [4:0] e_rs1, logic [4:0] e_rs2, logic [4:0] e_rd, logic [31:0] e_imm,
                              logic [2:0] e_f3, logic [31:0] e_pc);
    vec_t t;
    t.v = v; t.m = m; t.d0 = d0; t.d1 = d1; t.pc = pc; t.ordy = ordy;
    t.e_v = e_v; t.e_r = e_r; t.e_cnt = e_cnt; t.e_op = e_op; t.e_rs1 = e_rs1; t.e_rs2 = e_rs2;
    t.e_rd = e_rd; t.e_imm = e_imm; t.e_f3 = e_f3; t.e_pc = e_pc;
    return t;
  endfunction

  vec_t tbl [13];

  initial begin
    tbl[0]  = mk(1, 2'b11, I_A, I_B, 32'h100, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 2'b00, 0, 0, 0, 1, 1, 1, 2, OP_OP_IMM, 0, 0, 1, 5, 0, 32'h100);
    tbl[2]  = mk(0, 2'b00, 0, 0, 0, 1, 1, 1, 1, OP_LUI, 0, 0, 1, 0, 0, 32'h104);
    tbl[3]  = mk(1, 2'b11, I_Z, I_Q, 32'h200, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[4]  = mk(1, 2'b11, I_S, I_J, 32'h300, 1, 1, 1, 2, OP_INVAL, 0, 0, 0, 0, 0, 32'h200);
    tbl[5]  = mk(1, 2'b01, I_R, 0, 32'h400, 1, 1, 0, 3, OP_BRANCH, 0, 0, 0, 32'hFFFFFFFC, 0, 32'h204);
    tbl[6]  = mk(1, 2'b01, I_R, 0, 32'h400, 1, 1, 1, 2, OP_STORE, 1, 2, 0, 8, 2, 32'h300);
    tbl[7]  = mk(0, 2'b00, 0, 0, 0, 1, 1, 1, 2, OP_JAL, 0, 0, 1, 16, 0, 32'h304);
    tbl[8]  = mk(0, 2'b00, 0, 0, 0, 1, 1, 1, 1, OP_OP, 1, 2, 3, 2, 0, 32'h400);
    tbl[9]  = mk(1, 2'b00, I_A, I_B, 32'h480, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[10] = mk(1, 2'b01, I_X, 0, 32'h500, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[11] = mk(0, 2'b00, 0, 0, 0, 1, 1, 1, 1, OP_INVAL, 0, 0, 0, 0, 7, 32'h500);
    tbl[12] = mk(0, 2'b00, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_mask = '0; in_data = '0; in_pc = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    idle(1'b0);
    chk_flow("reset", 1'b0, 1'b1, 3'd0);

    for (int k = 0; k < 13; k++) begin
      drive(tbl[k].v, tbl[k].m, tbl[k].d0, tbl[k].d1, tbl[k].pc, tbl[k].ordy, 1'b0);
      chk_flow($sformatf("tbl%0d", k), tbl[k].e_v, tbl[k].e_r, tbl[k].e_cnt);
      if (tbl[k].e_v)
        chk_dec($sformatf("tbl%0d", k), tbl[k].e_op, tbl[k].e_rs1, tbl[k].e_rs2, tbl[k].e_rd,
                tbl[k].e_imm, tbl[k].e_f3, tbl[k].e_pc);
    end

    // fill with consumer stalled: only two of four beats fit
    for (int b = 0; b < 4; b++) begin
      drive(1'b1, 2'b11, I_A, I_B, 32'h600 + 32'(8 * b), 1'b0, 1'b0);
      chk($sformatf("fill%0d.in_ready", b), in_ready, b < 2);
      chk($sformatf("fill%0d.out_count", b), out_count, (b < 2) ? 2 * b : 4);
      if (b > 0) begin
        chk($sformatf("fill%0d.out_pc", b), out_pc, 32'h600);
        chk($sformatf("fill%0d.op", b), out_data[53:50], OP_OP_IMM);
      end
    end
    idle(1'b0);
    chk_flow("full", 1'b1, 1'b0, 3'd4);
    chk("full.out_pc", out_pc, 32'h600);
    for (int k = 0; k < 4; k++) begin
      idle(1'b1);
      chk($sformatf("drain%0d.out_valid", k), out_valid, 1'b1);
      chk($sformatf("drain%0d.out_pc", k), out_pc, 32'h600 + 32'(4 * k));
      chk($sformatf("drain%0d.op", k), out_data[53:50], (k % 2 == 0) ? OP_OP_IMM : OP_LUI);
    end
    idle(1'b0);
    chk_flow("drained", 1'b0, 1'b1, 3'd0);

    // tail wraps 3->0 during a simultaneous enqueue/dequeue
    drive(1'b1, 2'b01, I_A, 32'h0, 32'h700, 1'b0, 1'b0);
    chk_flow("wrap1", 1'b0, 1'b1, 3'd0);
    drive(1'b1, 2'b11, I_B, I_S, 32'h710, 1'b0, 1'b0);
    chk_flow("wrap2", 1'b1, 1'b1, 3'd1);
    idle(1'b1);
    chk_flow("wrap3", 1'b1, 1'b0, 3'd3);
    chk("wrap3.out_pc", out_pc, 32'h700);
    drive(1'b1, 2'b01, I_J, 32'h0, 32'h720, 1'b1, 1'b0);
    chk_flow("wrap4", 1'b1, 1'b1, 3'd2);
    chk("wrap4.out_pc", out_pc, 32'h710);
    idle(1'b1);
    chk_flow("wrap5", 1'b1, 1'b1, 3'd2);
    chk_dec("wrap5", OP_STORE, 1, 2, 0, 8, 2, 32'h714);
    idle(1'b1);
    chk_flow("wrap6", 1'b1, 1'b1, 3'd1);
    chk_dec("wrap6", OP_JAL, 0, 0, 1, 16, 0, 32'h720);
    drive(1'b1, 2'b01, I_R, 32'h0, 32'h740, 1'b0, 1'b0);
    chk_flow("wrap7", 1'b0, 1'b1, 3'd0);
    idle(1'b1);
    chk_dec("wrap8", OP_OP, 1, 2, 3, 2, 0, 32'h740);

    // flush with a beat offered
    drive(1'b1, 2'b11, I_A, I_B, 32'h800, 1'b0, 1'b0);
    drive(1'b1, 2'b01, I_S, 32'h0, 32'h808, 1'b0, 1'b0);
    chk_flow("flush0", 1'b1, 1'b1, 3'd2);
    drive(1'b1, 2'b11, I_J, I_R, 32'h900, 1'b1, 1'b1);
    chk_flow("flush1", 1'b0, 1'b0, 3'd3);
    idle(1'b1);
    chk_flow("flush2", 1'b0, 1'b1, 3'd0);
    drive(1'b1, 2'b01, I_R, 32'h0, 32'hA00, 1'b0, 1'b0);
    chk_flow("flush3", 1'b0, 1'b1, 3'd0);
    idle(1'b1);
    chk_flow("flush4", 1'b1, 1'b1, 3'd1);
    chk_dec("flush4", OP_OP, 1, 2, 3, 2, 0, 32'hA00);
    idle(1'b0);
    chk_flow("flush5", 1'b0, 1'b1, 3'd0);

    // reset mid-operation discards everything
    drive(1'b1, 2'b11, I_A, I_B, 32'hB00, 1'b0, 1'b0);
    idle(1'b0);
    rst = 1'b1;
    chk("rstmid.pre_count", out_count, 3'd2);
    idle(1'b1);
    rst = 1'b0;
    chk_flow("rstmid.post", 1'b0, 1'b1, 3'd0);
    idle(1'b0);
    chk_flow("rstmid.hold", 1'b0, 1'b1, 3'd0);

    // empty buffer, consumer ready, single-lane beat
    drive(1'b1, 2'b01, I_A, 32'h0, 32'hC00, 1'b1, 1'b0);
`ifdef DECODE_QUEUE_BYPASS_EN
    chk_flow("lat0", 1'b1, 1'b1, 3'd0);
    chk_dec("lat0", OP_OP_IMM, 0, 0, 1, 5, 0, 32'hC00);
    idle(1'b1);
    chk_flow("lat1", 1'b0, 1'b1, 3'd0);
`else
    chk_flow("lat0", 1'b0, 1'b1, 3'd0);
    idle(1'b1);
    chk_flow("lat1", 1'b1, 1'b1, 3'd1);
    chk_dec("lat1", OP_OP_IMM, 0, 0, 1, 5, 0, 32'hC00);
`endif
    idle(1'b0);
    chk_flow("lat2", 1'b0, 1'b1, 3'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
